// File: rtl/rgb_frame_buffer.sv
// rgb_frame_buffer: per-channel masked pixel store with registered reads.
// Define FB_CLEAR_EN to include the sequential frame-clear FSM.
module rgb_frame_buffer #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int CH    = 3,
  parameter int DW    = 8,
  parameter int CW    = 11
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [CW-1:0]    wr_x,
  input  logic [CW-1:0]    wr_y,
  input  logic [CH*DW-1:0] wr_data,
  input  logic [CH-1:0]    wr_mask,
  input  logic             rd_en,
  input  logic [CW-1:0]    rd_x,
  input  logic [CW-1:0]    rd_y,
  output logic [CH*DW-1:0] rd_data,
  output logic             rd_valid,
  input  logic             clear_req,
  input  logic [CH*DW-1:0] clear_value,
  output logic             busy
);
  localparam int DEPTH = H_RES * V_RES;
  localparam int AW    = $clog2(DEPTH);

  logic [CH*DW-1:0] mem [DEPTH];
  logic [CH*DW-1:0] rd_data_d, rd_data_q;
  logic             rd_valid_d, rd_valid_q;
  logic             wr_in, rd_in, wr_ok;
  logic [AW-1:0]    wr_addr, rd_addr;

  assign wr_in   = 32'(wr_x) < H_RES && 32'(wr_y) < V_RES;
  assign rd_in   = 32'(rd_x) < H_RES && 32'(rd_y) < V_RES;
  assign wr_addr = AW'(32'(wr_y) * H_RES + 32'(wr_x));
  assign rd_addr = AW'(32'(rd_y) * H_RES + 32'(rd_x));

`ifdef FB_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t        state_d, state_q;
  logic [AW-1:0] cnt_d, cnt_q;
  logic          busy_d, busy_q;
  logic          last;

  assign last = 32'(cnt_q) == DEPTH - 1;

  always_comb begin
    state_d = state_q == IDLE ? (clear_req ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
    cnt_d   = state_q == CLEAR && !last ? cnt_q + 1'b1 : '0;
    busy_d  = state_d == CLEAR;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // a clear request wins over a write issued in the same cycle
  assign wr_ok = wr_en && wr_in && !reset && state_q == IDLE && !clear_req;
  assign busy  = busy_q;
`else
  logic unused_ok;
  assign unused_ok = ^{clear_req, clear_value};
  assign wr_ok     = wr_en && wr_in && !reset;
  assign busy      = 1'b0;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (wr_ok)
      for (int c = 0; c < CH; c++)
        if (wr_mask[c]) mem[wr_addr][c*DW +: DW] <= wr_data[c*DW +: DW];
`ifdef FB_CLEAR_EN
    if (state_q == CLEAR && !reset) mem[cnt_q] <= clear_value;
`endif
  end

  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_en ? (rd_in ? mem[rd_addr] : '0) : rd_data_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
endmodule

// File: tb/tb_rgb_frame_buffer.sv
// tb_rgb_frame_buffer: random traffic against a pixel-array model plus directed pixel cases.
module tb_rgb_frame_buffer;
  localparam int H = 4, V = 3, N = H * V;
`ifdef FB_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, wr_en, rd_en, clear_req, rd_valid, busy;
  logic [10:0] wr_x, wr_y, rd_x, rd_y;
  logic [23:0] wr_data, rd_data, clear_value;
  logic [2:0]  wr_mask;

  rgb_frame_buffer #(.H_RES(H), .V_RES(V), .CH(3), .DW(8), .CW(11)) dut (
    .CLOCK_50(clk), .reset(reset), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .wr_mask(wr_mask), .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
    .rd_data(rd_data), .rd_valid(rd_valid), .clear_req(clear_req),
    .clear_value(clear_value), .busy(busy)
  );

  int total = 0, bad = 0;
  bit chk_on = 1'b0;
  logic [23:0] m [N];
  logic [23:0] pre [N];
  logic [23:0] e_data = '0;
  bit e_valid = 1'b0, e_busy = 1'b0;
  int cpos = 0;

  function automatic bit inr(input logic [10:0] x, input logic [10:0] y);
    return x < H && y < V;
  endfunction

  function automatic int ad(input logic [10:0] x, input logic [10:0] y);
    return int'(y) * H + int'(x);
  endfunction

  task automatic cmp(input string n, input logic [23:0] a, input logic [23:0] b);
    total++;
    if (a !== b) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, a, b, $time);
    end
  endtask

  // model: pixel array, reads see pre-write contents, clear fills one pixel per cycle
  always @(posedge clk) begin
    if (reset) begin
      e_valid = 1'b0;
      e_data  = '0;
      e_busy  = 1'b0;
    end else begin
      if (rd_en) begin
        e_valid = 1'b1;
        e_data  = inr(rd_x, rd_y) ? m[ad(rd_x, rd_y)] : 24'h0;
      end else e_valid = 1'b0;
      if (e_busy) begin
        m[cpos] = clear_value;
        cpos++;
        e_busy = cpos < N;
      end else if (CLR && clear_req) begin
        e_busy = 1'b1;
        cpos   = 0;
      end else if (wr_en && inr(wr_x, wr_y))
        for (int c = 0; c < 3; c++)
          if (wr_mask[c]) m[ad(wr_x, wr_y)][c*8 +: 8] = wr_data[c*8 +: 8];
    end
  end

  always @(negedge clk) if (chk_on) begin
    cmp("rd_valid", {23'h0, rd_valid}, {23'h0, e_valid});
    cmp("rd_data", rd_data, e_data);
    cmp("busy", {23'h0, busy}, {23'h0, e_busy});
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic quiet;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic wr(input int x, input int y, input logic [23:0] d, input logic [2:0] k);
    wr_en = 1'b1;
    wr_x = 11'(x);
    wr_y = 11'(y);
    wr_data = d;
    wr_mask = k;
  endtask

  task automatic rd(input int x, input int y);
    rd_en = 1'b1;
    rd_x = 11'(x);
    rd_y = 11'(y);
  endtask

  task automatic preload;
    for (int i = 0; i < N; i++) begin
      pre[i] = 24'($urandom);
      wr(i % H, i / H, pre[i], 3'b111);
      tick;
    end
    quiet;
  endtask

  initial begin
    int nb;
    reset = 1'b1;
    quiet;
    wr_x = '0; wr_y = '0; rd_x = '0; rd_y = '0;
    wr_data = '0; wr_mask = '0; clear_value = '0;
    tick;
    tick;
    chk_on = 1'b1;
    cmp("reset_valid", {23'h0, rd_valid}, 24'h0);
    cmp("reset_data", rd_data, 24'h0);
    cmp("reset_busy", {23'h0, busy}, 24'h0);
    reset = 1'b0;
    preload;
    wr(2, 1, 24'h112233, 3'b111); tick; quiet;
    rd(2, 1); tick; quiet;
    cmp("full_write_valid", {23'h0, rd_valid}, 24'h1);
    cmp("full_write", rd_data, 24'h112233);
    tick;
    cmp("idle_valid", {23'h0, rd_valid}, 24'h0);
    cmp("idle_hold", rd_data, 24'h112233);
    wr(2, 1, 24'hAABBCC, 3'b010); tick; quiet;
    rd(2, 1); tick; quiet;
    cmp("masked_write", rd_data, 24'h11BB33);
    wr(4, 0, 24'hFFFFFF, 3'b111); tick; quiet;
    rd(4, 0); tick;
    cmp("oor_read", rd_data, 24'h0);
    cmp("oor_valid", {23'h0, rd_valid}, 24'h1);
    rd(0, 0); tick; quiet;
    cmp("oor_no_alias", rd_data, pre[0]);
    wr(1, 1, 24'h010203, 3'b111); tick;
    wr(1, 1, 24'h040506, 3'b111); rd(1, 1); tick; quiet;
    cmp("rbw_old", rd_data, 24'h010203);
    rd(1, 1); tick; quiet;
    cmp("rbw_new", rd_data, 24'h040506);
    if (CLR) begin
      clear_req = 1'b1;
      clear_value = 24'h0A0B0C;
      wr(0, 0, 24'hFFFFFF, 3'b111);
      tick; quiet;
      nb = 0;
      for (int k = 0; k < 100 && busy; k++) begin
        nb++;
        wr(0, 0, 24'hFFFFFF, 3'b111);
        clear_req = 1'($urandom);
        tick;
      end
      quiet;
      cmp("busy_cycles", 24'(nb), 24'd12);
      for (int i = 0; i < N; i++) begin
        rd(i % H, i / H); tick;
        cmp("clear_px", rd_data, 24'h0A0B0C);
      end
      quiet;
      preload;
      clear_req = 1'b1;
      clear_value = 24'h123456;
      tick; quiet;
      repeat (5) tick;
      reset = 1'b1; tick; reset = 1'b0;
      cmp("abort_busy", {23'h0, busy}, 24'h0);
      for (int i = 0; i < N; i++) begin
        rd(i % H, i / H); tick;
        cmp("abort_px", rd_data, i < 5 ? 24'h123456 : pre[i]);
      end
      quiet;
    end else begin
      clear_req = 1'b1;
      clear_value = 24'h0A0B0C;
      wr(0, 0, 24'h5A5A5A, 3'b111);
      tick; quiet;
      cmp("noclr_busy", {23'h0, busy}, 24'h0);
      rd(0, 0); tick; quiet;
      cmp("noclr_write", rd_data, 24'h5A5A5A);
    end
    for (int i = 0; i < 400; i++) begin
      wr_en = 1'($urandom);
      wr_x = 11'($urandom_range(0, 5));
      wr_y = 11'($urandom_range(0, 4));
      wr_data = 24'($urandom);
      wr_mask = 3'($urandom);
      rd_en = 1'($urandom);
      rd_x = 11'($urandom_range(0, 5));
      rd_y = 11'($urandom_range(0, 4));
      clear_req = $urandom_range(0, 49) == 0;
      clear_value = 24'($urandom);
      reset = $urandom_range(0, 79) == 0;
      tick;
    end
    quiet;
    reset = 1'b0;
    repeat (14) tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rgb_frame_buffer.md
RGB_FRAME_BUFFER -- requirements
Module: rgb_frame_buffer

Interface
REQ-001 SHALL provide parameter H_RES, default 640, pixels per line.
REQ-002 SHALL provide parameter V_RES, default 480, lines per frame.
REQ-003 SHALL provide parameter CH, default 3, number of colour channels.
REQ-004 SHALL provide parameter DW, default 8, bits per channel.
REQ-005 SHALL provide parameter CW, default 11, coordinate width.
REQ-006 SHALL have port CLOCK_50, input, 1, sole clock; all logic on rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port wr_en, input, 1, write strobe.
REQ-009 SHALL have port wr_x / wr_y, input, CW each, write coordinates.
REQ-010 SHALL have port wr_data, input, CH*DW, packed pixel; channel 0 in the LSBs.
REQ-011 SHALL have port wr_mask, input, CH, per-channel write enable.
REQ-012 SHALL have port rd_en, input, 1, read strobe.
REQ-013 SHALL have port rd_x / rd_y, input, CW each, read coordinates.
REQ-014 SHALL have port rd_data, output reg, CH*DW, read pixel.
REQ-015 SHALL have port rd_valid, output reg, 1, rd_data qualifier.
REQ-016 SHALL have port clear_req, input, 1, start frame clear.
REQ-017 SHALL have port clear_value, input, CH*DW, fill pixel.
REQ-018 SHALL have port busy, output reg, 1, clear in progress.

Function
REQ-019 SHALL store H_RES*V_RES pixels at linear address y*H_RES+x; address width clog2(H_RES*V_RES).
REQ-020 SHALL, when wr_en=1, not busy and the coordinate is in range, write channel c only where wr_mask[c]=1; unmasked channels keep their contents.
REQ-021 SHALL drop writes with wr_x>=H_RES or wr_y>=V_RES, with no side effect.
REQ-022 SHALL register rd_data and rd_valid exactly 1 cycle after rd_en=1; rd_valid=0 in cycles following rd_en=0, and rd_data holds its last value.
REQ-023 SHALL return all-zero rd_data, with rd_valid=1, for out-of-range reads.
REQ-024 SHALL return pre-write data when the read and the write target the same address in the same cycle (read-before-write).
REQ-025 SHALL serve reads normally while busy=1; contents reflect clear progress.
REQ-026 SHALL implement FSM IDLE->CLEAR on clear_req=1 in IDLE; CLEAR writes clear_value to all channels, one address per cycle, ascending from 0.
REQ-027 SHALL return CLEAR->IDLE after address H_RES*V_RES-1 is written; busy=1 exactly H_RES*V_RES cycles, rising the cycle after clear_req is sampled.
REQ-028 SHALL sample clear_value every CLEAR cycle (not latched).
REQ-029 SHALL give clear priority over a simultaneous wr_en: the write is dropped in the clear_req cycle and throughout busy.
REQ-030 SHALL ignore clear_req while busy=1; there is no restart.

Reset
REQ-031 SHALL, on reset=1 at a clock edge, set rd_data=0, rd_valid=0, busy=0, FSM=IDLE and clear counter=0.
REQ-032 SHALL abort any clear on reset mid-operation; memory contents are not reset, and partially cleared pixels remain.
REQ-033 SHALL let reset override rd_en, wr_en and clear_req in the same cycle; the write is dropped.

Configuration
REQ-034 SHALL, with macro FB_CLEAR_EN defined, include the clear FSM per REQ-026..030.
REQ-035 SHALL, with FB_CLEAR_EN undefined, ignore clear_req and clear_value, tie busy to 0, and accept writes whenever wr_en=1.

Verification (H_RES=4, V_RES=3, CH=3, DW=8)
REQ-036 SHALL cover: write (2,1)=0x112233 with mask 3'b111, then read (2,1) -> rd_valid=1 and rd_data=0x112233 one cycle later.
REQ-037 SHALL cover: write (2,1)=0xAABBCC with mask 3'b010, then read -> 0x11BB33.
REQ-038 SHALL cover: write (4,0)=0xFFFFFF, then read (4,0) -> 0x000000; read (0,0) -> unchanged.
REQ-039 SHALL cover: clear_req with clear_value=0x0A0B0C plus concurrent wr_en to (0,0) -> busy high exactly 12 cycles; all 12 reads return 0x0A0B0C.
REQ-040 SHALL cover: reset after 5 clear cycles -> busy=0 next cycle; addresses 0-4 = clear_value, addresses 5-11 keep prior data.
REQ-041 SHALL cover: same-cycle write and read of (1,1), old 0x010203, new 0x040506 -> read returns 0x010203; next read returns 0x040506.
